mux_7seg_scan: RTL and testbench
================================

# mux_7seg_scan

Parametrised multi-digit successor to the single-digit multiplexed 7-segment decoder. It holds an internal NUM_DIGITS-wide BCD up/down counter and time-multiplexes either that counter or an external hex word onto one shared 7-segment bus. The shared bus is driven with a one-hot digit enable and a programmable scan rate. It sits between the board-level display pins and any logic that needs to show a count or a status word.

## Interface
- NUM_DIGITS, 4, number of digits scanned and counter width in BCD digits; legal range 1..8.
- SCAN_DIV, 4, clocks each digit stays enabled; must be ≥1.

- clk  input  1  system clock, rising edge.
- clr  input  1  reset; asynchronous, active-high.
- tick  input  1  count-enable pulse; the counter steps once per clk edge with tick=1.
- up_dn  input  1  counter direction: 1 = up, 0 = down.
- select  input  1  display source: 0 = BCD counter, 1 = data_in shown as hex.
- data_in  input  4*NUM_DIGITS  external word; nibble k goes to digit k.
- seg_out  output  7  segments {g,f,e,d,c,b,a}; 1 = lit.
- dig_en  output  NUM_DIGITS  one-hot digit enable; 1 = digit on.
- carry  output  1  one-cycle pulse on counter wrap, in either direction.

## Operation
- **Counter.** Per-digit BCD, 0..9.
  - Up: 9 rolls to 0 and ripples to the next digit within the same edge.
  - Down: 0 rolls to 9 and borrows from the next digit.
  - Full up-wrap: all nines → all zeros, with carry=1.
  - Full down-wrap: all zeros → all nines, with carry=1.
  - The counter always runs, independent of select.
- **Scan.**
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances 0 → NUM_DIGITS-1, then wraps to 0.
  - With NUM_DIGITS=1 the index stays at 0.
- **Source nibble.** For digit index k:
  - select=0: BCD digit k of the counter.
  - select=1: data_in[4k+3:4k].
- **Encoding** (hex 0..F), in order: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - A BCD digit is never >9, so select=0 uses codes 0..9 only.
- **Output registers.** seg_out and dig_en are registered every clk from the current index and source. dig_en = 1<<index.
- **Reset (clr=1).** Counter=0, prescaler=0, index=0, seg_out=7'h00, dig_en=0, carry=0.
  - Reset is asynchronous; asserting it mid-scan or mid-count clears immediately, with no partial update.

## Timing
- Latency is 1 clk from index/source to pins.
  - A change on select or data_in appears on seg_out at the next edge, for the currently enabled digit.
- First edge after clr deasserts: dig_en=...0001, seg_out=encoding of digit 0.
- Each digit holds for exactly SCAN_DIV clks; a full frame is NUM_DIGITS*SCAN_DIV clks.
- Counter and carry:
  - The counter updates on the edge sampling tick=1.
  - When select=0, the new value is visible on seg_out at the following edge for the enabled digit.
  - carry is registered and goes high on the same edge the wrapped value is loaded.
- Simultaneous tick with a select change: the counter still steps; the display source switches on the same edge.
- tick held high counts every clk. up_dn is sampled on the same edge as tick.

## Configuration
- MUX7SEG_LZB_EN defined: leading-zero blanking.
  - A digit k>0 outputs 7'h00 when it and every digit above it are zero.
  - Digit 0 is never blanked.
  - Applies in both select modes, using the nibbles actually shown.
  - dig_en is unaffected.
- MUX7SEG_LZB_EN undefined: all digits are always shown, including leading zeros.

## Structure
- Package mux7seg_pkg holds:
  - the 16-entry segment encoding constant;
  - the SEG_BLANK (7'h00) constant;
  - the BCD digit width constant (4).
- Sub-module seg7_encode: combinational 4-bit → 7-bit encoder, instantiated once on the muxed nibble.
- Counter, prescaler, index and blanking logic stay in mux_7seg_scan.

## Test plan
All scenarios use NUM_DIGITS=4 and SCAN_DIV=4.
- **Reset and first frame.** Release clr → dig_en walks 0001, 0010, 0100, 1000 at 4-clk intervals, then wraps to 0001. seg_out=3F throughout without LZB. With LZB, digits 1..3 show 00.
- **Up-count wrap.** Preload by ticking up to 9999, then tick once with up_dn=1 → counter reads 0000 and carry is high for exactly 1 clk.
- **Down-count wrap.** From 0000, tick once with up_dn=0 → counter reads 9999, carry pulses once, and each digit displays 6F.
- **Hex mode.** select=1, data_in=16'hA5F0 → digits 0..3 show 3F, 71, 6D, 77.
- **Mid-scan reset.** With tick high, assert clr while dig_en=0100 → all outputs go to 0 immediately with no clk edge. After release, the count restarts from 0000.
- **Leading-zero blanking (MUX7SEG_LZB_EN).** Counter=0042 → digits 3..0 show 00, 00, 66, 5B.

Source files
------------

// File: rtl/mux7seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment table,
// blank code and BCD digit width.
package mux7seg_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Entry k occupies bits [7k+6:7k]; segments {g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [16*SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex nibble to 7-segment pattern encoder.
module seg7_encode
  import mux7seg_pkg::*;
(
  input  logic [BCD_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    for (int k = 0; k < 16; k++) begin
      if (nib_i == BCD_W'(k)) seg_c_o = SEG_TABLE[SEG_W*k +: SEG_W];
    end
  end

endmodule

// File: rtl/mux_7seg_scan.sv
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment scanner.
// Define MUX7SEG_LZB_EN to enable leading-zero blanking.
module mux_7seg_scan
  import mux7seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        tick,
  input  logic                        up_dn,
  input  logic                        select,
  input  logic [BCD_W*NUM_DIGITS-1:0] data_in,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        carry
);

  localparam int unsigned WORD_W = BCD_W * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [WORD_W-1:0]     cnt_q, cnt_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  carry_q, carry_d;

  logic                  ripple;
  logic [WORD_W-1:0]     src_word;
  logic [BCD_W-1:0]      src_nib;
  logic [SEG_W-1:0]      seg_enc;
  logic                  blank_c;

  // BCD counter: ripple stays high while every lower digit has rolled over.
  always_comb begin
    cnt_d  = cnt_q;
    ripple = tick;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ripple) begin
        if (up_dn) begin
          if (cnt_q[BCD_W*k +: BCD_W] == BCD_W'(9)) begin
            cnt_d[BCD_W*k +: BCD_W] = '0;
          end else begin
            cnt_d[BCD_W*k +: BCD_W] = cnt_q[BCD_W*k +: BCD_W] + BCD_W'(1);
            ripple = 1'b0;
          end
        end else begin
          if (cnt_q[BCD_W*k +: BCD_W] == '0) begin
            cnt_d[BCD_W*k +: BCD_W] = BCD_W'(9);
          end else begin
            cnt_d[BCD_W*k +: BCD_W] = cnt_q[BCD_W*k +: BCD_W] - BCD_W'(1);
            ripple = 1'b0;
          end
        end
      end
    end
    carry_d = ripple;
  end

  // Scan prescaler and digit index.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Source selection for the currently indexed digit.
  always_comb begin
    src_word = select ? data_in : cnt_q;
    src_nib  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) src_nib = src_word[BCD_W*k +: BCD_W];
    end
  end

`ifdef MUX7SEG_LZB_EN
  logic zero_run;

  // A digit above 0 is blank when it and every higher shown nibble is zero.
  always_comb begin
    zero_run = 1'b1;
    blank_c  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (src_word[BCD_W*k +: BCD_W] == '0);
      if ((k > 0) && (idx_q == IDX_W'(k)) && zero_run) blank_c = 1'b1;
    end
  end
`else
  always_comb begin
    blank_c = 1'b0;
  end
`endif

  seg7_encode u_enc (
    .nib_i   (src_nib),
    .seg_c_o (seg_enc)
  );

  always_comb begin
    seg_d = blank_c ? SEG_BLANK : seg_enc;
    dig_d = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      dig_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      carry_q <= carry_d;
    end
  end

  assign seg_out = seg_q;
  assign dig_en  = dig_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_mux_7seg_scan.sv
// Self-checking bench for mux_7seg_scan (4 digits, scan divider 4) using a
// table of vectors, corner sequences and a decimal-integer reference model.
module tb_mux_7seg_scan;

  localparam int ND = 4;
  localparam int SD = 4;
`ifdef MUX7SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        tick;
  logic        up_dn;
  logic        select;
  logic [15:0] data_in;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        carry;

  mux_7seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk     (clk),
    .clr     (clr),
    .tick    (tick),
    .up_dn   (up_dn),
    .select  (select),
    .data_in (data_in),
    .seg_out (seg_out),
    .dig_en  (dig_en),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          t;
    bit          u;
    bit          s;
    logic [15:0] d;
    logic [6:0]  seg;
    logic [3:0]  dig;
    bit          car;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_count;
  int          m_cycle;
  logic [6:0]  enc [16];
  vec_t        vecs [33];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(int v, bit sel, logic [15:0] d, int idx);
    int nib [4];
    int p;
    bit z;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      nib[k] = sel ? int'(d[4*k +: 4]) : (v / p) % 10;
      p = p * 10;
    end
    if (LZB && idx > 0) begin
      z = 1'b1;
      for (int k = idx; k < 4; k++) if (nib[k] != 0) z = 1'b0;
      if (z) return 7'h00;
    end
    return enc[nib[idx]];
  endfunction

  function automatic int cur_idx();
    return (m_cycle / SD) % ND;
  endfunction

  // Apply inputs for one edge, compare outputs after it, advance the model.
  task automatic drive_edge(bit t, bit u, bit s, logic [15:0] d,
                            logic [6:0] es, logic [3:0] ed, bit ec, string tag);
    tick = t; up_dn = u; select = s; data_in = d;
    @(posedge clk);
    #1;
    check({tag, "_seg"}, 32'(seg_out), 32'(es));
    check({tag, "_dig"}, 32'(dig_en), 32'(ed));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    if (t) begin
      if (u) m_count = (m_count == 9999) ? 0 : m_count + 1;
      else   m_count = (m_count == 0) ? 9999 : m_count - 1;
    end
    m_cycle++;
    @(negedge clk);
  endtask

  task automatic step_model(bit t, bit u, bit s, logic [15:0] d, string tag);
    logic [6:0] es;
    logic [3:0] ed;
    bit         ec;
    es = model_seg(m_count, s, d, cur_idx());
    ed = 4'(1 << cur_idx());
    ec = t && (u ? (m_count == 9999) : (m_count == 0));
    drive_edge(t, u, s, d, es, ed, ec, tag);
  endtask

  initial begin
    logic [3:0] dig_walk [4];
    logic [6:0] hex_seg  [4];
    logic [6:0] lz_seg   [4];
    int         idx;
    bit         found;

    enc = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    dig_walk = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    hex_seg  = '{7'h3F, 7'h71, 7'h6D, 7'h77};
    lz_seg   = LZB ? '{7'h5B, 7'h66, 7'h00, 7'h00} : '{7'h5B, 7'h66, 7'h3F, 7'h3F};
    for (int i = 0; i < 17; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b0, 16'h0000,
                  (LZB && ((i / 4) % 4) != 0) ? 7'h00 : 7'h3F,
                  dig_walk[(i / 4) % 4], 1'b0};
    for (int i = 17; i < 33; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b1, 16'hA5F0, hex_seg[(i / 4) % 4],
                  dig_walk[(i / 4) % 4], 1'b0};

    // Reset state
    clr = 1'b1; tick = 1'b0; up_dn = 1'b1; select = 1'b0; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_seg", 32'(seg_out), 32'h00);
    check("reset_dig", 32'(dig_en), 32'h0);
    check("reset_carry", 32'(carry), 32'h0);
    clr = 1'b0;
    m_count = 0;
    m_cycle = 0;

    // First frame and hex mode from the vector table
    for (int i = 0; i < 33; i++)
      drive_edge(vecs[i].t, vecs[i].u, vecs[i].s, vecs[i].d,
                 vecs[i].seg, vecs[i].dig, vecs[i].car, $sformatf("vec%0d", i));

    // Preload 9999 then up-wrap
    for (int i = 0; i < 10000 && m_count != 9999; i++)
      step_model(1'b1, 1'b1, 1'b0, 16'h0, "preload_up");
    step_model(1'b1, 1'b1, 1'b0, 16'h0, "up_wrap");
    check("carry_up_pulse", 32'(carry), 32'h1);
    step_model(1'b0, 1'b1, 1'b0, 16'h0, "after_up");
    check("carry_up_clear", 32'(carry), 32'h0);
    for (int i = 0; i < 16; i++) begin
      idx = cur_idx();
      step_model(1'b0, 1'b1, 1'b0, 16'h0, "zero_frame");
      check("zero_frame_explicit", 32'(seg_out), (LZB && idx != 0) ? 32'h00 : 32'h3F);
    end

    // Down-wrap from 0000
    step_model(1'b1, 1'b0, 1'b0, 16'h0, "down_wrap");
    check("carry_down_pulse", 32'(carry), 32'h1);
    for (int i = 0; i < 16; i++) begin
      step_model(1'b0, 1'b0, 1'b0, 16'h0, "nines_frame");
      check("nines_explicit", 32'(seg_out), 32'h6F);
      if (i == 0) check("carry_down_clear", 32'(carry), 32'h0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++)
      step_model(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), "rand");

    // Mid-scan asynchronous reset with tick high
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idx = cur_idx();
      step_model(1'b1, 1'b1, 1'b0, 16'h0, "pre_clr");
      if (idx == 2) found = 1'b1;
    end
    check("midscan_dig_before_clr", 32'(dig_en), 32'h4);
    clr = 1'b1;
    #1;
    check("async_clr_seg", 32'(seg_out), 32'h00);
    check("async_clr_dig", 32'(dig_en), 32'h0);
    check("async_clr_carry", 32'(carry), 32'h0);
    @(posedge clk);
    #1;
    check("held_clr_dig", 32'(dig_en), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    m_count = 0;
    m_cycle = 0;
    drive_edge(1'b0, 1'b1, 1'b0, 16'h0, 7'h3F, 4'b0001, 1'b0, "restart_first");
    for (int i = 0; i < 15; i++)
      step_model(1'b0, 1'b1, 1'b0, 16'h0, "restart_frame");

    // Counter = 0042: leading-zero behaviour
    for (int i = 0; i < 42; i++)
      step_model(1'b1, 1'b1, 1'b0, 16'h0, "preload_42");
    for (int i = 0; i < 16; i++) begin
      idx = cur_idx();
      step_model(1'b0, 1'b1, 1'b0, 16'h0, "frame_42");
      check("frame_42_explicit", 32'(seg_out), 32'(lz_seg[idx]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
